// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port data RAM with round-robin fairness and a bounded burst lock.
// Define RAM_ARB_FIXED_PRIO_EN to make master 0 always win contention in IDLE (rr_ptr held at 0).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no lock held; arbitrate by rr_ptr (or fixed priority)
// LOCK0 | master 0 owns the bus while it keeps requesting, until MAX_HOLD
// LOCK1 | master 1 owns the bus while it keeps requesting, until MAX_HOLD
module ram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rr_ptr;
    logic              rr_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              win_lock;
    logic              hold_full;

    // Requests are masked while reset is high so no grant or write escapes.
    assign req0      = m0_req_i & ~rst;
    assign req1      = m1_req_i & ~rst;
    assign hold_full = (hold_cnt == HOLD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        win_lock  = 1'b0;
        state_nxt = state;
        rr_nxt    = rr_ptr;
        hold_nxt  = hold_cnt;

        case (state)
            LOCK0: begin
                if (req0) begin
                    if (hold_full && req1) gnt1 = 1'b1;
                    else                   gnt0 = 1'b1;
                end else begin
                    gnt1 = req1;
                end
            end
            LOCK1: begin
                if (req1) begin
                    if (hold_full && req0) gnt0 = 1'b1;
                    else                   gnt1 = 1'b1;
                end else begin
                    gnt0 = req0;
                end
            end
            default: begin
                if (req0 && req1) begin
                    gnt0 = ~rr_ptr;
                    gnt1 = rr_ptr;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase

        if (gnt0 || gnt1) begin
            win_lock = gnt1 ? m1_lock_i : m0_lock_i;
`ifdef RAM_ARB_FIXED_PRIO_EN
            rr_nxt = 1'b0;
`else
            rr_nxt = gnt0;
`endif
            if (win_lock) begin
                if (state == (gnt1 ? LOCK1 : LOCK0)) begin
                    if (!hold_full) hold_nxt = hold_cnt + 1'b1;
                end else begin
                    state_nxt = gnt1 ? LOCK1 : LOCK0;
                    hold_nxt  = HOLD_W'(1);
                end
            end else begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        end else begin
            // In a lock state no grant means the owner dropped its request.
            state_nxt = IDLE;
            hold_nxt  = '0;
        end
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    always_comb begin
        ram_wr_en_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (gnt0) begin
            ram_wr_en_o = m0_we_i;
            ram_addr_o  = m0_addr_i;
            ram_wdata_o = m0_wdata_i;
        end else if (gnt1) begin
            ram_wr_en_o = m1_we_i;
            ram_addr_o  = m1_addr_i;
            ram_wdata_o = m1_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rdata_o  <= '0;
        end else begin
            m0_rvalid_o <= gnt0 & ~m0_we_i;
            m1_rvalid_o <= gnt1 & ~m1_we_i;
            if (gnt0 && !m0_we_i) m0_rdata_o <= ram_rdata_i;
            if (gnt1 && !m1_we_i) m1_rdata_o <= ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: bench-side RAM, reference memory and per-master read scoreboards.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m0_we_i, m0_lock_i;
    logic [31:0] m0_addr_i, m0_wdata_i;
    logic        m0_gnt_o, m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m1_req_i, m1_we_i, m1_lock_i;
    logic [31:0] m1_addr_i, m1_wdata_i;
    logic        m1_gnt_o, m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        ram_wr_en_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

    logic [31:0] ram     [0:255];
    logic [31:0] mem_ref [0:255];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        exp_rv0, exp_rv1;
    logic [31:0] exp_rd0, exp_rd1;
    int          n_pass = 0;
    int          n_chk  = 0;

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_wr_en_o(ram_wr_en_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    assign ram_rdata_i = ram[ram_addr_o[9:2]];
    always @(posedge clk) if (ram_wr_en_o) ram[ram_addr_o[9:2]] <= ram_wdata_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: sample 1 ns before the rising edge, then return at the next falling edge.
    task automatic cycle(input logic eg0, input logic eg1);
        logic        w_we;
        logic [31:0] w_addr, w_wdata;
        #4;
        check("m0_rvalid", {31'd0, m0_rvalid_o}, {31'd0, exp_rv0});
        if (exp_rv0 && q0.size() > 0) exp_rd0 = q0.pop_front();
        check("m0_rdata", m0_rdata_o, exp_rd0);
        check("m1_rvalid", {31'd0, m1_rvalid_o}, {31'd0, exp_rv1});
        if (exp_rv1 && q1.size() > 0) exp_rd1 = q1.pop_front();
        check("m1_rdata", m1_rdata_o, exp_rd1);
        check("m0_gnt", {31'd0, m0_gnt_o}, {31'd0, eg0});
        check("m1_gnt", {31'd0, m1_gnt_o}, {31'd0, eg1});
        if (eg0 || eg1) begin
            w_we    = eg0 ? m0_we_i    : m1_we_i;
            w_addr  = eg0 ? m0_addr_i  : m1_addr_i;
            w_wdata = eg0 ? m0_wdata_i : m1_wdata_i;
            check("ram_addr", ram_addr_o, w_addr);
            check("ram_wr_en", {31'd0, ram_wr_en_o}, {31'd0, w_we});
            check("ram_wdata", ram_wdata_o, w_wdata);
            if (w_we)     mem_ref[w_addr[9:2]] = w_wdata;
            else if (eg0) q0.push_back(mem_ref[w_addr[9:2]]);
            else          q1.push_back(mem_ref[w_addr[9:2]]);
        end else begin
            check("idle_addr", ram_addr_o, 32'd0);
            check("idle_wdata", ram_wdata_o, 32'd0);
            check("idle_wr_en", {31'd0, ram_wr_en_o}, 32'd0);
        end
        exp_rv0 = eg0 & ~m0_we_i;
        exp_rv1 = eg1 & ~m1_we_i;
        @(negedge clk);
    endtask

    task automatic clear_model();
        exp_rv0 = 1'b0; exp_rv1 = 1'b0;
        exp_rd0 = '0;   exp_rd1 = '0;
        q0.delete();    q1.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        cycle(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic both_rr;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = '0;
            mem_ref[i] = '0;
        end
        rst = 1'b1;
        m0_req_i = 0; m0_we_i = 0; m0_lock_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_lock_i = 0; m1_addr_i = '0; m1_wdata_i = '0;
        clear_model();
        @(negedge clk);

        // Requests during reset: no grant, no write.
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h10; m0_wdata_i = 32'h1111_1111;
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h14; m1_wdata_i = 32'h2222_2222;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        m1_req_i = 0;
        rst = 1'b0;

        // Basic write then read of the same word.
        m0_wdata_i = 32'hDEAD_BEEF;
        cycle(1'b1, 1'b0);
        m0_we_i = 0;
        cycle(1'b1, 1'b0);
        m0_req_i = 0;
        cycle(1'b0, 1'b0);
        check("rd_deadbeef", m0_rdata_o, 32'hDEAD_BEEF);

        // Continuous reads from both masters.
        do_reset();
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h10;
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h14;
        for (int k = 0; k < 8; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            both_rr = 1'b0;
`else
            both_rr = k[0];
`endif
            cycle(~both_rr, both_rr);
        end

        // Same-cycle write by m0 and read by m1 of one word.
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h20; m0_wdata_i = 32'h55AA_1234;
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h20;
        cycle(1'b1, 1'b0);
        m0_req_i = 0;
        cycle(1'b0, 1'b1);
        m1_req_i = 0;
        cycle(1'b0, 1'b0);
        check("wr_rd_same", m1_rdata_o, 32'h55AA_1234);

        // Locked 20-beat burst by m1 against one pending m0 write: forced handover after 16.
        m1_req_i = 1; m1_we_i = 1; m1_lock_i = 1;
        m1_addr_i = 32'h100; m1_wdata_i = 32'hA000;
        cycle(1'b0, 1'b1);
        m0_req_i = 1; m0_we_i = 1; m0_lock_i = 0; m0_addr_i = 32'h40; m0_wdata_i = 32'h1234_5678;
        for (int k = 1; k < 16; k++) begin
            m1_addr_i = 32'h100 + 32'(4 * k); m1_wdata_i = 32'hA000 + 32'(k);
            cycle(1'b0, 1'b1);
        end
        m1_addr_i = 32'h100 + 32'(4 * 16); m1_wdata_i = 32'hA000 + 32'd16;
        cycle(1'b1, 1'b0);
        m0_req_i = 0;
        for (int k = 16; k < 20; k++) begin
            m1_addr_i = 32'h100 + 32'(4 * k); m1_wdata_i = 32'hA000 + 32'(k);
            m1_lock_i = (k != 19);
            cycle(1'b0, 1'b1);
        end
        m1_req_i = 0; m1_lock_i = 0;
        cycle(1'b0, 1'b0);

        // Locked burst with m0 idle: all beats go to m1, hold count saturates.
        m1_req_i = 1; m1_we_i = 1; m1_lock_i = 1;
        for (int k = 0; k < 20; k++) begin
            m1_addr_i = 32'h200 + 32'(4 * k); m1_wdata_i = 32'hB000 + 32'(k);
            cycle(1'b0, 1'b1);
        end
        m1_addr_i = 32'h250; m1_wdata_i = 32'hB014;
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h100;
        cycle(1'b1, 1'b0);
        m0_req_i = 0; m1_lock_i = 0;
        cycle(1'b0, 1'b1);
        check("forced_rd", m0_rdata_o, 32'hA000);
        m1_we_i = 0; m1_addr_i = 32'h24C;
        cycle(1'b0, 1'b1);
        m1_req_i = 0;
        cycle(1'b0, 1'b0);
        check("burst_rd", m1_rdata_o, 32'hB013);
        m0_addr_i = 32'h40;
        m0_req_i = 1;
        cycle(1'b1, 1'b0);
        m0_req_i = 0;
        cycle(1'b0, 1'b0);
        check("handover_wr", m0_rdata_o, 32'h1234_5678);

        // Reset right after a read grant.
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h10;
        cycle(1'b1, 1'b0);
        check("pre_rst_rvalid", {31'd0, m0_rvalid_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
        check("rst_rdata", m0_rdata_o, 32'd0);
        clear_model();
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h14;
        @(negedge clk);
        cycle(1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b1, 1'b0);
        m0_req_i = 0; m1_req_i = 0;
        cycle(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
